// File: rtl/pcie_frame_pull_if.sv
// Bundle of the frame-pull handshake signals: start/status, the upstream read
// buffer side and the output stream toward the PCIe DMA write engine.
interface pcie_frame_pull_if #(
    parameter int unsigned DATA_W = 128
) ();
    logic              start;
    logic              busy;
    logic              frame_done;
    logic              rd_fsync;
    logic              rd_en;
    logic              vout_de;
    logic [DATA_W-1:0] vout_data;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;
    logic              err_unexp_de;

    // Frame-pull engine side
    modport master (
        input  start,
        input  vout_de,
        input  vout_data,
        input  m_tready,
        output busy,
        output frame_done,
        output rd_fsync,
        output rd_en,
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        output m_tuser,
        output err_unexp_de
    );

    // Environment side: requester, upstream buffer and DMA engine
    modport slave (
        output start,
        output vout_de,
        output vout_data,
        output m_tready,
        input  busy,
        input  frame_done,
        input  rd_fsync,
        input  rd_en,
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        input  m_tuser,
        input  err_unexp_de
    );
endinterface

// File: rtl/pcie_frame_pull.sv
// Frame pull stage: restarts the upstream frame buffer, waits for its DDR
// prefetch, paces reads with a credit scheme into a small FWFT FIFO and
// re-issues the words as a line/frame framed valid/ready stream.
module pcie_frame_pull #(
    parameter int unsigned H_NUM      = 1920,
    parameter int unsigned V_NUM      = 1080,
    parameter int unsigned PIX_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FSYNC_HOLD = 8,
    parameter int unsigned FSYNC_WAIT = 2048,
    parameter int unsigned RD_LAT     = 2
) (
    input logic              vout_clk,
    input logic              vout_rstn,
    pcie_frame_pull_if.master bus
);
    localparam int unsigned LINE_WORDS  = H_NUM * PIX_WIDTH / 128;
    localparam int unsigned FRAME_WORDS = LINE_WORDS * V_NUM;
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = AW + 1;
    localparam int unsigned IW          = $clog2(RD_LAT + 1);
    localparam int unsigned TMAX        = (FSYNC_WAIT > FSYNC_HOLD) ? FSYNC_WAIT : FSYNC_HOLD;
    localparam int unsigned TW          = $clog2(TMAX + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFsync  = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StStream = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [23:0]       issued_q;
    logic [RD_LAT-1:0] infl_sr_q;
    logic [IW-1:0]     inflight;
    logic [CW:0]       credit_sum;
    logic              rd_en_w;

    logic [127:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q;
    logic              de_expected;
    logic              push, pop, valid;

    logic [11:0]       col_q, line_q;
    logic              col_last, frame_last;
    logic              err_q, done_q;

    // Outstanding reads: one bit per rd_en issued in the last RD_LAT cycles
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(infl_sr_q[i]);
        end
    end

    // Credit check counts words already buffered plus words still in flight
    assign credit_sum = {1'b0, cnt_q} + (CW + 1)'(inflight);
    assign rd_en_w    = (state_q == StStream) && (issued_q < 24'(FRAME_WORDS)) &&
                        (credit_sum < (CW + 1)'(FIFO_DEPTH));

    // The oldest shift-register bit is the read whose word returns this cycle
    assign de_expected = infl_sr_q[RD_LAT-1];
    assign push        = bus.vout_de & de_expected;
    assign valid       = (cnt_q != '0);
    assign pop         = valid & bus.m_tready;

    assign col_last   = (col_q == 12'(LINE_WORDS - 1));
    assign frame_last = col_last && (line_q == 12'(V_NUM - 1));

    // Frame sequencing: restart pulse, prefetch wait, credit-paced reads, drain
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFsync;
                    timer_d = '0;
                end
            end
            StFsync: begin
                if (timer_q == TW'(FSYNC_HOLD - 1)) begin
                    state_d = StWait;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWait: begin
                if (timer_q == TW'(FSYNC_WAIT - 1)) begin
                    state_d = StStream;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStream: begin
                if (rd_en_w && (issued_q == 24'(FRAME_WORDS - 1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && frame_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and phase timer
    always_ff @(posedge vout_clk or negedge vout_rstn) begin
        if (!vout_rstn) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Read issue counter (cleared when a new frame is accepted) and in-flight history
    always_ff @(posedge vout_clk or negedge vout_rstn) begin
        if (!vout_rstn) begin
            issued_q  <= '0;
            infl_sr_q <= '0;
        end else begin
            if (state_q == StIdle && bus.start) begin
                issued_q <= '0;
            end else if (rd_en_w) begin
                issued_q <= issued_q + 24'd1;
            end
            infl_sr_q[0] <= rd_en_w;
            for (int i = 1; i < RD_LAT; i++) begin
                infl_sr_q[i] <= infl_sr_q[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may both act in one cycle
    always_ff @(posedge vout_clk or negedge vout_rstn) begin
        if (!vout_rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge vout_clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.vout_data;
        end
    end

    // Output position counters, advanced only on handshake
    always_ff @(posedge vout_clk or negedge vout_rstn) begin
        if (!vout_rstn) begin
            col_q  <= '0;
            line_q <= '0;
        end else if (pop) begin
            if (col_last) begin
                col_q  <= '0;
                line_q <= (line_q == 12'(V_NUM - 1)) ? 12'd0 : line_q + 12'd1;
            end else begin
                col_q <= col_q + 12'd1;
            end
        end
    end

    // Sticky unexpected-word flag and end-of-frame pulse
    always_ff @(posedge vout_clk or negedge vout_rstn) begin
        if (!vout_rstn) begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (bus.vout_de && !de_expected) begin
                err_q <= 1'b1;
            end
            done_q <= (state_q == StDrain) && pop && frame_last;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.rd_fsync     = (state_q == StFsync);
    assign bus.rd_en        = rd_en_w;
    assign bus.m_tvalid     = valid;
    // Framing and data are qualified by valid so every output idles at zero
    assign bus.m_tdata      = valid ? mem_q[rptr_q] : '0;
    assign bus.m_tlast      = valid && col_last;
    assign bus.m_tuser      = valid && (col_q == 12'd0) && (line_q == 12'd0);
    assign bus.err_unexp_de = err_q;
    assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_pcie_frame_pull.sv
// Directed bench for pcie_frame_pull with a small 64x4 frame (12 words/line).
module tb_pcie_frame_pull;
    localparam int unsigned LW    = 12;
    localparam int unsigned TOTAL = 48;

    logic clk;
    logic rstn;
    logic inj_de;
    int   n_tests;
    int   n_fail;
    int   exp_idx;
    int   widx;
    bit   fsync_seen;

    pcie_frame_pull_if bus ();

    pcie_frame_pull #(
        .H_NUM (64),
        .V_NUM (4)
    ) dut (
        .vout_clk  (clk),
        .vout_rstn (rstn),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] word_of(input int i);
        return {32'(i) + 32'h1234_0000, ~32'(i), 32'(i * 7), 32'hCAFE_0000 ^ 32'(i)};
    endfunction

    // Upstream buffer model: word returned RD_LAT=2 cycles after rd_en, index restarts on fsync
    initial begin
        logic p0, p1;
        int   d0, d1;
        p0 = 1'b0; p1 = 1'b0; d0 = 0; d1 = 0; widx = 0;
        bus.vout_de   = 1'b0;
        bus.vout_data = '0;
        forever begin
            @(negedge clk);
            if (!rstn || bus.rd_fsync) begin
                p0 = 1'b0; p1 = 1'b0; widx = 0;
                bus.vout_de   = inj_de;
                bus.vout_data = '0;
            end else begin
                bus.vout_de   = p1 | inj_de;
                bus.vout_data = p1 ? word_of(d1) : '0;
                p1 = p0; d1 = d0;
                p0 = bus.rd_en; d0 = widx;
                if (bus.rd_en) widx++;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 128'(bus.busy), 0);
        chk({tag, "_done"}, 128'(bus.frame_done), 0);
        chk({tag, "_fsync"}, 128'(bus.rd_fsync), 0);
        chk({tag, "_rd_en"}, 128'(bus.rd_en), 0);
        chk({tag, "_tvalid"}, 128'(bus.m_tvalid), 0);
        chk({tag, "_tdata"}, bus.m_tdata, 0);
        chk({tag, "_tlast"}, 128'(bus.m_tlast), 0);
        chk({tag, "_tuser"}, 128'(bus.m_tuser), 0);
        chk({tag, "_err"}, 128'(bus.err_unexp_de), 0);
    endtask

    // Pulse start, then measure rd_fsync width and first rd_en cycle relative to T
    task automatic start_frame(input string tag);
        int c, fs_cnt, fs_last, first_rd;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        c = 1; fs_cnt = 0; fs_last = -1; first_rd = -1;
        chk({tag, "_busy_on"}, 128'(bus.busy), 1);
        chk({tag, "_fsync_first"}, 128'(bus.rd_fsync), 1);
        while (c < 3000) begin
            if (bus.rd_fsync) begin fs_cnt++; fs_last = c; end
            if (bus.rd_en) begin first_rd = c; break; end
            @(negedge clk); c++;
        end
        chk({tag, "_fsync_len"}, 128'(fs_cnt), 8);
        chk({tag, "_fsync_last"}, 128'(fs_last), 8);
        chk({tag, "_first_rd_en"}, 128'(first_rd), 1 + 8 + 2048);
        exp_idx    = 0;
        fsync_seen = 1'b0;
    endtask

    // Stall the sink for 100 cycles; credit must hold fifo+inflight at 16
    task automatic stall_sink();
        @(posedge clk); #1 bus.m_tready = 1'b0;
        repeat (100) @(negedge clk);
        chk("t3_rd_en_stalled", 128'(bus.rd_en), 0);
        chk("t3_outstanding", 128'(widx - exp_idx), 16);
        chk("t3_tvalid_held", 128'(bus.m_tvalid), 1);
        @(posedge clk); #1 bus.m_tready = 1'b1;
    endtask

    // Consume words, checking data and framing; optional start pulse, stall or reset
    task automatic collect(input string tag, input int upto, input int pulse_at,
                           input int stall_at, input int reset_at);
        int cyc;
        cyc = 0;
        while (exp_idx < upto && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (bus.start) bus.start = 1'b0;
            if (bus.rd_fsync) fsync_seen = 1'b1;
            if (bus.m_tvalid && bus.m_tready) begin
                chk({tag, "_tdata"}, bus.m_tdata, word_of(exp_idx));
                chk({tag, "_tlast"}, 128'(bus.m_tlast), 128'((exp_idx % LW) == LW - 1));
                chk({tag, "_tuser"}, 128'(bus.m_tuser), 128'(exp_idx == 0));
                exp_idx++;
                if (exp_idx == pulse_at) bus.start = 1'b1;
                if (exp_idx == stall_at) stall_sink();
                if (exp_idx == reset_at) begin
                    @(posedge clk); #1 rstn = 1'b0;
                    #1 chk_idle_outputs({tag, "_async_rst"});
                    return;
                end
            end
        end
        chk({tag, "_word_count"}, 128'(exp_idx), 128'(upto));
    endtask

    // Called right after the final handshake was sampled
    task automatic end_frame(input string tag);
        chk({tag, "_done_not_early"}, 128'(bus.frame_done), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 128'(bus.frame_done), 1);
        chk({tag, "_busy_off"}, 128'(bus.busy), 0);
        chk({tag, "_tvalid_empty"}, 128'(bus.m_tvalid), 0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 128'(bus.frame_done), 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_idx = 0; fsync_seen = 1'b0;
        rstn = 1'b0; inj_de = 1'b0;
        bus.start = 1'b0; bus.m_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // T1/T2: plain frame, fsync timing, order and framing
        start_frame("t1");
        collect("t1", TOTAL, -1, -1, -1);
        end_frame("t1");
        chk("t1_no_err", 128'(bus.err_unexp_de), 0);

        // T4: start during STREAM is ignored
        start_frame("t4");
        collect("t4", TOTAL, 20, -1, -1);
        chk("t4_no_refsync", 128'(fsync_seen), 0);
        end_frame("t4");

        // T3: sink stalled mid-line
        start_frame("t3");
        collect("t3", TOTAL, -1, 18, -1);
        end_frame("t3");
        chk("t3_no_err", 128'(bus.err_unexp_de), 0);

        // T5: stray vout_de while idle
        @(posedge clk); #2 inj_de = 1'b1;
        @(posedge clk); #2 inj_de = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_err_set", 128'(bus.err_unexp_de), 1);
        chk("t5_tvalid_low", 128'(bus.m_tvalid), 0);
        chk("t5_busy_low", 128'(bus.busy), 0);
        repeat (20) @(negedge clk);
        chk("t5_err_sticky", 128'(bus.err_unexp_de), 1);
        chk("t5_tvalid_still_low", 128'(bus.m_tvalid), 0);

        // T6: async reset at word 20, then a full fresh frame
        start_frame("t6a");
        collect("t6a", TOTAL, -1, -1, 20);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        start_frame("t6b");
        collect("t6b", TOTAL, -1, -1, -1);
        end_frame("t6b");
        chk("t6_no_err", 128'(bus.err_unexp_de), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
